// File: rtl/aes_word_loader_pkg.sv
// Shared widths and the loader state encoding for the AES word loader.
package aes_word_loader_pkg;
  localparam int BLOCK_W         = 128;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int CNT_W           = 2;

  typedef enum logic [1:0] {
    LOAD_KEY,
    LOAD_DATA,
    WAIT_ENC,
    UNLOAD
  } state_e;
endpackage

// File: rtl/aes_word_loader_word_shift_reg.sv
// 128-bit MSW-first register: words shift in at the LSW end, the MSW leaves first.
module word_shift_reg
  import aes_word_loader_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [WORD_W-1:0]  word_i,
  input  logic [BLOCK_W-1:0] data_i,
  output logic [BLOCK_W-1:0] q_o
);
  logic [BLOCK_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i)        q_d = '0;
    else if (load_i)  q_d = data_i;
    else if (shift_i) q_d = {q_q[BLOCK_W-WORD_W-1:0], word_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// File: rtl/aes_word_loader.sv
// Collects key/plaintext words for an AES core, waits for it, and streams the ciphertext back.
module aes_word_loader
  import aes_word_loader_pkg::*;
#(
  parameter int          KEY_RELOAD     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               resetModule,
  input  logic [WORD_W-1:0]  wordIn,
  input  logic               wordValid,
  output logic               wordReady,
  output logic [BLOCK_W-1:0] inputData,
  output logic [BLOCK_W-1:0] key,
  output logic               inputsLoadedFlag,
  input  logic               dataEncryptedFlag,
  input  logic [BLOCK_W-1:0] outputData,
  output logic [WORD_W-1:0]  resultWord,
  output logic               resultValid,
  input  logic               resultReady,
  output logic               timeoutFlag
);
  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        tmo_q, tmo_d;
  logic               tmo_pulse_q, tmo_pulse_d;
  logic               armed_q;
  logic               xfer, last_word;
  logic               key_shift, data_shift, data_clr, res_load, res_shift;
  logic [BLOCK_W-1:0] res_q;

  // Ready is held off until the first edge after reset release.
  assign wordReady = armed_q & ((state_q == LOAD_KEY) | (state_q == LOAD_DATA));
  assign xfer      = wordValid & wordReady;
  assign last_word = (cnt_q == LAST_WORD);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    tmo_pulse_d = 1'b0;
    key_shift   = 1'b0;
    data_shift  = 1'b0;
    data_clr    = 1'b0;
    res_load    = 1'b0;
    res_shift   = 1'b0;
    case (state_q)
      LOAD_KEY: if (xfer) begin
        key_shift = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (last_word) state_d = LOAD_DATA;
      end
      LOAD_DATA: if (xfer) begin
        data_shift = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (last_word) begin
          state_d = WAIT_ENC;
          tmo_d   = '0;
        end
      end
      WAIT_ENC: begin
        if (dataEncryptedFlag) begin
          res_load = 1'b1;
          state_d  = UNLOAD;
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          // Abandon the block but keep the key.
          tmo_pulse_d = 1'b1;
          data_clr    = 1'b1;
          state_d     = LOAD_DATA;
        end else if (TMO_EN) begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      UNLOAD: if (resultReady) begin
        res_shift = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (last_word) state_d = (KEY_RELOAD != 0) ? LOAD_KEY : LOAD_DATA;
      end
      default: state_d = LOAD_KEY;
    endcase
  end

  always_ff @(posedge clock or negedge resetModule) begin
    if (!resetModule) begin
      state_q     <= LOAD_KEY;
      cnt_q       <= '0;
      tmo_q       <= '0;
      tmo_pulse_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      tmo_pulse_q <= tmo_pulse_d;
      armed_q     <= 1'b1;
    end
  end

  word_shift_reg u_key (
    .clk_i(clock), .rst_ni(resetModule), .clr_i(1'b0), .load_i(1'b0),
    .shift_i(key_shift), .word_i(wordIn), .data_i('0), .q_o(key)
  );

  word_shift_reg u_data (
    .clk_i(clock), .rst_ni(resetModule), .clr_i(data_clr), .load_i(1'b0),
    .shift_i(data_shift), .word_i(wordIn), .data_i('0), .q_o(inputData)
  );

  word_shift_reg u_res (
    .clk_i(clock), .rst_ni(resetModule), .clr_i(1'b0), .load_i(res_load),
    .shift_i(res_shift), .word_i('0), .data_i(outputData), .q_o(res_q)
  );

  assign inputsLoadedFlag = (state_q == WAIT_ENC);
  assign resultValid      = (state_q == UNLOAD);
  assign resultWord       = res_q[BLOCK_W-1 -: WORD_W];
  assign timeoutFlag      = tmo_pulse_q;
endmodule
